uart_rx_ctrl: RTL and testbench

- Parametrised UART receive controller, successor to the fixed 8-bit receive control unit.
- Runs entirely in the CLK domain. Oversamples the serial line RXD on a one-cycle sample-tick enable RXC, supplied by the baud generator at OVERSAMPLE × baud rate.
- Frames start/data/parity/stop, delivers parallel DATA with a one-cycle RXRDY strobe, and flags parity and framing errors.
- Sits between the baud generator and the RX FIFO / register interface.

---
 rtl/uart_rx_ctrl.sv | 122 ++++++++++++
 tb/tb_uart_rx_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: oversampling UART receiver framing start/data/parity/stop with parity and framing error flags
module uart_rx_ctrl #(
  parameter int SIZE       = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            RXC,
  input  logic            RXD,
  output logic            RXEN,
  output logic            RXRDY,
  output logic [SIZE-1:0] DATA,
  output logic            PERR,
  output logic            FERR
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(SIZE);
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_BRK} state_t;
  state_t          state_q, state_d;
  logic [1:0]      sync_q;
  logic            rxd_s;
  logic [TW-1:0]   tick_q, tick_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [SIZE-1:0] shift_q, shift_d, data_q, data_d;
  logic            perr_int_q, perr_int_d, ferr_int_q, ferr_int_d;
  logic            rxen_q, rxen_d, rxrdy_q, rxrdy_d, perr_q, perr_d, ferr_q, ferr_d;
  logic            last, half, stop_bad;
  assign rxd_s    = sync_q[1];
  assign last     = tick_q == TW'(OVERSAMPLE - 1);
  assign half     = tick_q == TW'(OVERSAMPLE / 2 - 1);
  assign stop_bad = ferr_int_q | ~rxd_s;
  // next-state: every decision waits for an RXC tick, so gaps in RXC freeze the receiver
  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    perr_int_d = perr_int_q;
    ferr_int_d = ferr_int_q;
    rxrdy_d    = 1'b0;
    data_d     = data_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    if (RXC) begin
      tick_d = last ? '0 : tick_q + 1'b1;
      case (state_q)
        S_IDLE: begin
          tick_d     = '0;
          bit_d      = '0;
          perr_int_d = 1'b0;
          ferr_int_d = 1'b0;
          state_d    = rxd_s ? S_IDLE : S_START;
        end
        S_START: if (half) begin
          tick_d  = '0;
          state_d = rxd_s ? S_IDLE : S_DATA;
        end
        S_DATA: if (last) begin
          shift_d = {rxd_s, shift_q[SIZE-1:1]};
          bit_d   = (bit_q == BW'(SIZE - 1)) ? '0 : bit_q + 1'b1;
          state_d = (bit_q != BW'(SIZE - 1)) ? S_DATA : (PARITY != 0) ? S_PAR : S_STOP;
        end
        S_PAR: if (last) begin
          perr_int_d = ^shift_q ^ rxd_s ^ (PARITY == 1);
          state_d    = S_STOP;
        end
        S_STOP: if (last) begin
          ferr_int_d = stop_bad;
          bit_d      = bit_q + 1'b1;
          if (bit_q == BW'(STOP_BITS - 1)) begin
            rxrdy_d = 1'b1;
            data_d  = shift_q;
            perr_d  = (PARITY != 0) && perr_int_q;
            ferr_d  = stop_bad;
            bit_d   = '0;
            state_d = stop_bad ? S_BRK : S_IDLE;
          end
        end
        S_BRK: state_d = rxd_s ? S_IDLE : S_BRK;
        default: state_d = S_IDLE;
      endcase
    end
    rxen_d = state_d inside {S_START, S_DATA, S_PAR, S_STOP};
  end
  // state, synchroniser and registered outputs; reset aborts any frame in flight
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_q     <= 2'b11;
      state_q    <= S_IDLE;
      tick_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      perr_int_q <= 1'b0;
      ferr_int_q <= 1'b0;
      rxen_q     <= 1'b0;
      rxrdy_q    <= 1'b0;
      data_q     <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], RXD};
      state_q    <= state_d;
      tick_q     <= tick_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      perr_int_q <= perr_int_d;
      ferr_int_q <= ferr_int_d;
      rxen_q     <= rxen_d;
      rxrdy_q    <= rxrdy_d;
      data_q     <= data_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
    end
  end
  assign RXEN  = rxen_q;
  assign RXRDY = rxrdy_q;
  assign DATA  = data_q;
  assign PERR  = perr_q;
  assign FERR  = ferr_q;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: three receiver configurations driven by directed frames, checked against a frame-level model
module tb_uart_rx_ctrl;
  localparam int SZ  [3] = '{8, 8, 5};
  localparam int OS  [3] = '{16, 16, 8};
  localparam int PAR [3] = '{0, 2, 0};
  localparam int STB [3] = '{1, 2, 1};
  typedef struct {
    logic [8:0] d;
    logic       p;
    logic       f;
    int         t;
  } frame_t;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxc = 1'b0;
  logic [2:0] rxd = 3'b111;
  wire  [2:0] rxen, rdy, perr, ferr;
  wire  [7:0] d0, d1;
  wire  [4:0] d2;
  logic [8:0] dv [3];
  frame_t     exp_q [3][$];
  int         n_tests = 0;
  int         n_fail = 0;
  int         tick_n = 0;
  int         gap = 1;
  int         rdy_cnt [3] = '{0, 0, 0};
  logic [8:0] hd [3];
  logic       hp [3];
  logic       hf [3];
  logic       rst_seen = 1'b1;
  assign dv[0] = {1'b0, d0};
  assign dv[1] = {1'b0, d1};
  assign dv[2] = {4'b0, d2};
  uart_rx_ctrl #(.SIZE(8), .OVERSAMPLE(16), .PARITY(0), .STOP_BITS(1)) u0 (
    .CLK(clk), .RST(rst), .RXC(rxc), .RXD(rxd[0]), .RXEN(rxen[0]), .RXRDY(rdy[0]),
    .DATA(d0), .PERR(perr[0]), .FERR(ferr[0]));
  uart_rx_ctrl #(.SIZE(8), .OVERSAMPLE(16), .PARITY(2), .STOP_BITS(2)) u1 (
    .CLK(clk), .RST(rst), .RXC(rxc), .RXD(rxd[1]), .RXEN(rxen[1]), .RXRDY(rdy[1]),
    .DATA(d1), .PERR(perr[1]), .FERR(ferr[1]));
  uart_rx_ctrl #(.SIZE(5), .OVERSAMPLE(8), .PARITY(0), .STOP_BITS(1)) u2 (
    .CLK(clk), .RST(rst), .RXC(rxc), .RXD(rxd[2]), .RXEN(rxen[2]), .RXRDY(rdy[2]),
    .DATA(d2), .PERR(perr[2]), .FERR(ferr[2]));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // one RXC tick, then gap-1 idle clocks; tick_n counts completed tick edges
  task automatic tick();
    rxc = 1'b1;
    @(posedge clk);
    #1;
    rxc = 1'b0;
    tick_n++;
    repeat (gap - 1) begin
      @(posedge clk);
      #1;
    end
  endtask
  // drives one frame on line i and records what the receiver must report and when
  task automatic send_frame(input int i, input logic [8:0] data, input logic pb, input logic [1:0] stops);
    frame_t e;
    int ones;
    ones = $countones(data) + int'(pb);
    e.d = data;
    e.p = (PAR[i] == 0) ? 1'b0 : (PAR[i] == 1) ? (ones % 2 == 0) : (ones % 2 == 1);
    e.f = !stops[0] || (STB[i] == 2 && !stops[1]);
    e.t = tick_n + (SZ[i] + (PAR[i] != 0 ? 1 : 0) + STB[i]) * OS[i] + OS[i] / 2 + (gap == 1 ? 3 : 2);
    exp_q[i].push_back(e);
    rxd[i] = 1'b0;
    repeat (OS[i]) tick();
    for (int k = 0; k < SZ[i]; k++) begin
      if (k == 2) chk("rxen_busy", rxen[i], 1);
      rxd[i] = data[k];
      repeat (OS[i]) tick();
    end
    if (PAR[i] != 0) begin
      rxd[i] = pb;
      repeat (OS[i]) tick();
    end
    for (int k = 0; k < STB[i]; k++) begin
      rxd[i] = stops[k];
      repeat (OS[i]) tick();
    end
    chk("rxen_end", rxen[i], 0);
    chk("rdy_pending", exp_q[i].size(), 0);
    if (exp_q[i].size() != 0) exp_q[i].delete();
  endtask
  // compare process: every cycle, outputs either report the expected frame or hold the last one
  initial begin
    frame_t e;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (rst_seen) begin
          chk("reset_out", {rxen[i], rdy[i], perr[i], ferr[i], dv[i]}, 0);
          hd[i] = '0;
          hp[i] = 1'b0;
          hf[i] = 1'b0;
          exp_q[i].delete();
        end else if (rdy[i]) begin
          rdy_cnt[i]++;
          chk("rxen_at_rdy", rxen[i], 0);
          if (exp_q[i].size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_rdy: inst %0d got RXRDY with DATA %0h, required no RXRDY", i, dv[i]);
          end else begin
            e = exp_q[i].pop_front();
            chk("data", dv[i], e.d);
            chk("perr", perr[i], e.p);
            chk("ferr", ferr[i], e.f);
            chk("latency_ticks", tick_n, e.t);
            hd[i] = e.d;
            hp[i] = e.p;
            hf[i] = e.f;
          end
        end else begin
          chk("hold", {perr[i], ferr[i], dv[i]}, {hp[i], hf[i], hd[i]});
        end
      end
      rst_seen = rst;
    end
  end
  initial begin
    logic [7:0] v;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_rxen", rxen, 0);
    chk("rst_rdy", rdy, 0);
    chk("rst_data", {d0, d1, d2}, 0);
    chk("rst_err", {perr, ferr}, 0);
    repeat (20) tick();
    send_frame(0, 9'h0A5, 1'b0, 2'b11);
    chk("basic_data", d0, 8'hA5);
    chk("basic_cnt", rdy_cnt[0], 1);
    chk("basic_err", {perr[0], ferr[0]}, 0);
    repeat (16) tick();
    rxd[0] = 1'b0;
    repeat (6) tick();
    chk("fs_rxen_hi", rxen[0], 1);
    rxd[0] = 1'b1;
    repeat (24) tick();
    chk("fs_rxen_lo", rxen[0], 0);
    chk("fs_cnt", rdy_cnt[0], 1);
    chk("fs_data", d0, 8'hA5);
    v = 8'h5A;
    rxd[0] = 1'b0;
    repeat (16) tick();
    for (int k = 0; k < 4; k++) begin
      rxd[0] = v[k];
      repeat (16) tick();
    end
    rxd[0] = v[4];
    repeat (8) tick();
    chk("mr_rxen_busy", rxen[0], 1);
    rst = 1'b1;
    rxd[0] = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_data", d0, 0);
    chk("mr_rxen", rxen[0], 0);
    chk("mr_cnt", rdy_cnt[0], 1);
    repeat (32) tick();
    send_frame(0, 9'h03C, 1'b0, 2'b11);
    chk("mr_next_data", d0, 8'h3C);
    chk("mr_next_cnt", rdy_cnt[0], 2);
    send_frame(1, 9'h007, 1'b1, 2'b11);
    chk("par_ok", perr[1], 0);
    repeat (16) tick();
    send_frame(1, 9'h007, 1'b0, 2'b11);
    chk("par_bad", perr[1], 1);
    chk("par_data", d1, 8'h07);
    repeat (16) tick();
    send_frame(1, 9'h055, 1'b0, 2'b01);
    chk("frm_ferr", ferr[1], 1);
    chk("frm_data", d1, 8'h55);
    repeat (40 * 16) tick();
    chk("brk_rxen", rxen[1], 0);
    chk("brk_cnt", rdy_cnt[1], 3);
    rxd[1] = 1'b1;
    repeat (16) tick();
    send_frame(1, 9'h081, 1'b0, 2'b11);
    chk("brk_next_err", {perr[1], ferr[1]}, 0);
    chk("brk_next_data", d1, 8'h81);
    chk("brk_next_cnt", rdy_cnt[1], 4);
    gap = 3;
    repeat (8) tick();
    send_frame(2, 9'h01F, 1'b0, 2'b11);
    send_frame(2, 9'h000, 1'b0, 2'b11);
    chk("b2b_cnt", rdy_cnt[2], 2);
    chk("b2b_data", d2, 0);
    chk("b2b_err", {perr[2], ferr[2]}, 0);
    repeat (4) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
